mem_stage: RTL

MEM stage of the 32-bit MIPS pipeline. It consumes the EX/MEM pipeline register outputs and performs word loads and stores over a req/ack data-memory port. It stalls upstream while an access is outstanding and registers results into the MEM/WB boundary for the write-back stage. Misaligned accesses and unacknowledged accesses become bubbles with error pulses.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mem_stage_memwb_reg.sv | 31 +++
 rtl/mem_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-bit positions and
// the MEM-stage state type.
package mips_pkg;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline boundary: loads all fields when enabled, cleared
// asynchronously by reset.
module memwb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [1:0]  i_wb,
  input  logic [31:0] i_readData,
  input  logic [31:0] i_aluData,
  input  logic [4:0]  i_regd,
  output logic [1:0]  o_wb,
  output logic [31:0] o_readData,
  output logic [31:0] o_aluData,
  output logic [4:0]  o_regd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb       <= '0;
      o_readData <= '0;
      o_aluData  <= '0;
      o_regd     <= '0;
    end else if (i_en) begin
      o_wb       <= i_wb;
      o_readData <= i_readData;
      o_aluData  <= i_aluData;
      o_regd     <= i_regd;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word loads/stores over a req/ack port, stalling upstream
// while an access is outstanding; misaligned or timed-out accesses become bubbles.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [1:0]  WB_in,
  input  logic [1:0]  M_in,
  input  logic [31:0] ALUData_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  Regd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic [1:0]  WB_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUData_out,
  output logic [4:0]  Regd_out,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  mem_state_t    r_state, w_stateNext;
  logic [CW-1:0] r_count, w_countNext;
  logic          r_memReq, r_memWe, r_alignErr, r_busErr;
  logic [31:0]   r_memAddr, r_memWdata;

  logic          w_memOp, w_aligned;
  logic          w_launch, w_capture, w_bubble;
  logic          w_alignErr, w_busErr, w_stall;
  logic [31:0]   w_readData;
  logic [1:0]    w_wbIn;

  assign w_memOp   = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
  assign w_aligned = (ALUData_in[1:0] == 2'b00);
  assign w_wbIn    = {WB_in[WB_REGWRITE], WB_in[WB_MEMTOREG]};

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_bubble    = 1'b0;
    w_alignErr  = 1'b0;
    w_busErr    = 1'b0;
    w_stall     = 1'b0;
    w_readData  = '0;
    case (r_state)
      IDLE: begin
        if (!w_memOp) begin
          w_capture = 1'b1;
        end else if (!w_aligned) begin
          w_bubble   = 1'b1;
          w_alignErr = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_launch    = 1'b1;
          w_countNext = '0;
          w_stateNext = WAIT;
        end
      end
      WAIT: begin
        // An ack on the final wait cycle still completes the access.
        if (mem_ack) begin
          w_capture   = 1'b1;
          w_readData  = r_memWe ? 32'h0 : mem_rdata;
          w_stateNext = IDLE;
        end else if (r_count == LAST) begin
          w_bubble    = 1'b1;
          w_busErr    = 1'b1;
          w_stateNext = IDLE;
        end else begin
          w_stall     = 1'b1;
          w_countNext = r_count + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_alignErr <= 1'b0;
      r_busErr   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_memReq   <= (w_stateNext == WAIT);
      r_alignErr <= w_alignErr;
      r_busErr   <= w_busErr;
      // Request address/data persist after completion until the next launch.
      if (w_launch) begin
        r_memWe    <= M_in[M_MEMWRITE];
        r_memAddr  <= ALUData_in;
        r_memWdata <= WriteData_in;
      end
    end
  end

  memwb_reg u_memwb (
    .clk        (clk),
    .rst        (reset_in),
    .i_en       (w_capture | w_bubble),
    .i_wb       (w_bubble ? 2'b00 : w_wbIn),
    .i_readData (w_bubble ? 32'h0 : w_readData),
    .i_aluData  (w_bubble ? 32'h0 : ALUData_in),
    .i_regd     (w_bubble ? 5'd0 : Regd_in),
    .o_wb       (WB_out),
    .o_readData (ReadData_out),
    .o_aluData  (ALUData_out),
    .o_regd     (Regd_out)
  );

  assign stall_out = w_stall;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign align_err = r_alignErr;
  assign bus_err   = r_busErr;

endmodule
